// File: rtl/spi_alu_pkg.sv
// rtl/spi_alu_pkg.sv - shared types, constants and response packing for the SPI/ALU sequencer
package spi_alu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_OPS,
        ST_EXEC,
        ST_RESP,
        ST_WAIT_CS
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } alu_op_t;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

    localparam int RESP_N_BIT   = 7;
    localparam int RESP_Z_BIT   = 6;
    localparam int RESP_C_BIT   = 5;
    localparam int RESP_V_BIT   = 4;
    localparam int RESP_RES_LSB = 0;

    // Response byte as seen by the master: flags in the high nibble, result in the low nibble.
    function automatic logic [7:0] pack_resp(input logic n, input logic z, input logic c,
                                             input logic v, input logic [3:0] res);
        logic [7:0] b;
        b = '0;
        b[RESP_N_BIT] = n;
        b[RESP_Z_BIT] = z;
        b[RESP_C_BIT] = c;
        b[RESP_V_BIT] = v;
        b[RESP_RES_LSB +: 4] = res;
        return b;
    endfunction

endpackage

// File: rtl/spi_alu_sequencer_if.sv
// rtl/spi_alu_sequencer_if.sv - byte receiver, ALU and MISO-loader signals of the sequencer
interface spi_alu_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 2
);
    logic              cs_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_n;
    logic              alu_z;
    logic              alu_c;
    logic              alu_v;
    logic              tx_load;
    logic [7:0]        tx_data;
    logic              slave_ready;
    logic              busy;
    logic              err;

    modport slave (
        input  cs_n, rx_valid, rx_data, alu_result, alu_n, alu_z, alu_c, alu_v,
        output alu_a, alu_b, alu_op, tx_load, tx_data, slave_ready, busy, err
    );

    modport master (
        output cs_n, rx_valid, rx_data, alu_result, alu_n, alu_z, alu_c, alu_v,
        input  alu_a, alu_b, alu_op, tx_load, tx_data, slave_ready, busy, err
    );
endinterface

// File: rtl/cs_sync.sv
// rtl/cs_sync.sv - two-flop chip-select synchronizer with rise/fall pulses
module cs_sync (
    input  logic clk,
    input  logic rst,
    input  logic cs_n_raw,
    output logic cs_rise,
    output logic cs_fall
);
    logic s1, s2, s3;

    // Resync the raw chip select and keep one extra stage for edge detection; idle is deasserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= cs_n_raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign cs_rise = s2 & ~s3;
    assign cs_fall = ~s2 & s3;
endmodule

// File: rtl/spi_alu_sequencer.sv
// rtl/spi_alu_sequencer.sv - SPI frame to ALU transaction controller; option macro CMD_PARITY_EN
module spi_alu_sequencer
    import spi_alu_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int OP_W        = 2,
    parameter int ALU_LAT     = 0,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic               clk,
    input logic               rst,
    spi_alu_sequencer_if.slave bus
);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    state_t            state, state_d;
    logic              cs_rise, cs_fall;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [7:0]        tx_q;
    logic [TO_W-1:0]   to_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              timeout, exec_done, parity_bad;

    cs_sync u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .cs_n_raw(bus.cs_n),
        .cs_rise (cs_rise),
        .cs_fall (cs_fall)
    );

`ifdef CMD_PARITY_EN
    // Command byte is valid only with odd parity across all eight bits.
    assign parity_bad = ~(^bus.rx_data);
`else
    assign parity_bad = 1'b0;
`endif

    // Timeout fires in the TIMEOUT_CYC-th cycle spent waiting for the operand byte.
    assign timeout   = (to_cnt >= TO_W'(TIMEOUT_CYC - 1));
    assign exec_done = (lat_cnt >= LAT_W'(ALU_LAT));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Next-state: a cs deassertion aborts any frame, and wins over a coincident byte.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:    if (cs_fall) state_d = ST_GET_CMD;
            ST_GET_CMD: begin
                if (cs_rise)           state_d = ST_IDLE;
                else if (bus.rx_valid) state_d = parity_bad ? ST_RESP : ST_GET_OPS;
            end
            ST_GET_OPS: begin
                if (cs_rise)           state_d = ST_IDLE;
                else if (bus.rx_valid) state_d = ST_EXEC;
                else if (timeout)      state_d = ST_WAIT_CS;
            end
            ST_EXEC: begin
                if (cs_rise)        state_d = ST_IDLE;
                else if (exec_done) state_d = ST_RESP;
            end
            ST_RESP:    state_d = cs_rise ? ST_IDLE : ST_WAIT_CS;
            ST_WAIT_CS: if (cs_rise) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs: handshake flags decoded from state, error/load pulses qualified by abort.
    always_comb begin
        bus.busy        = (state != ST_IDLE);
        bus.slave_ready = (state == ST_WAIT_CS);
        bus.tx_load     = 1'b0;
        bus.err         = 1'b0;
        case (state)
            ST_GET_CMD: bus.err = bus.rx_valid & ~cs_rise & parity_bad;
            ST_GET_OPS: bus.err = cs_rise | (~bus.rx_valid & timeout);
            ST_EXEC:    bus.err = cs_rise;
            ST_RESP: begin
                bus.err     = cs_rise;
                bus.tx_load = ~cs_rise;
            end
            default: ;
        endcase
    end

    // Datapath: latch opcode, drive ALU operands, capture the response, run the cycle counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_op_q <= '0;
            tx_q     <= '0;
            to_cnt   <= '0;
            lat_cnt  <= '0;
        end else begin
            if (state == ST_GET_CMD && bus.rx_valid && !cs_rise) begin
                op_q <= bus.rx_data[OP_W-1:0];
                if (parity_bad) tx_q <= ERR_BYTE;
            end
            if (state == ST_GET_OPS && state_d == ST_EXEC) begin
                a_q      <= bus.rx_data[7:4];
                b_q      <= bus.rx_data[3:0];
                alu_op_q <= op_q;
            end
            if (state == ST_EXEC && state_d == ST_RESP)
                tx_q <= pack_resp(bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v, bus.alu_result);
            // Held at zero outside GET_OPS, so each entry starts a fresh count.
            if (state != ST_GET_OPS)                  to_cnt <= '0;
            else if (to_cnt != TO_W'(TIMEOUT_CYC))    to_cnt <= to_cnt + 1'b1;
            if (state != ST_EXEC)                     lat_cnt <= '0;
            else if (!exec_done)                      lat_cnt <= lat_cnt + 1'b1;
        end
    end

    assign bus.alu_a   = a_q;
    assign bus.alu_b   = b_q;
    assign bus.alu_op  = alu_op_q;
    assign bus.tx_data = tx_q;
endmodule
